// File: rtl/adder_pkg.sv
// adder_pkg: shared types for the chunked adder/subtractor
package adder_pkg;
  typedef enum logic {ADD, SUB} op_t;
  typedef struct packed {logic n, z, c, v;} flags_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit ripple adder exposing the carry into the MSB
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout  = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/sub, CHUNK bits per clock with a carry register.
// Define CHUNKED_ADDER_FLAGS_EN to generate registered {N,Z,C,V} flags.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output flags_t           flags
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, nsum;
  logic [IW-1:0]    idx;
  logic             carry, co, c_msb;
  logic [CHUNK-1:0] s;
  chunk_adder #(.W(CHUNK)) u_chunk (
    .a    (a_q[idx*CHUNK +: CHUNK]),
    .b    (b_q[idx*CHUNK +: CHUNK]),
    .cin  (carry),
    .sum  (s),
    .cout (co),
    .c_msb(c_msb)
  );
  // sum is built in place; nsum is its value after the current chunk lands
  always_comb begin
    nsum = sum;
    nsum[idx*CHUNK +: CHUNK] = s;
  end
`ifdef CHUNKED_ADDER_FLAGS_EN
  flags_t flags_q;
  assign flags = flags_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
  assign flags = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef CHUNKED_ADDER_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= a;
          b_q      <= op == SUB ? ~b : b;
          carry    <= op == SUB ? 1'b1 : cin;
          idx      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          sum   <= nsum;
          carry <= co;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            idx       <= '0;
            cout      <= co;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef CHUNKED_ADDER_FLAGS_EN
            flags_q   <= '{n: nsum[WIDTH-1], z: nsum == '0, c: co, v: c_msb ^ co};
`endif
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
